// File: rtl/bayer_pkg.sv
// Shared Bayer CFA definitions for the mosaic / demosaic / Sobel video stages.
package bayer_pkg;

  // 2x2 colour filter array layouts, named by the top-left 2x2 block
  localparam logic [1:0] BAYER_RGGB = 2'd0;
  localparam logic [1:0] BAYER_GRBG = 2'd1;
  localparam logic [1:0] BAYER_GBRG = 2'd2;
  localparam logic [1:0] BAYER_BGGR = 2'd3;

  // CFA phase {row parity, column parity} after pattern correction
  localparam logic [1:0] PHASE_R  = 2'b00;
  localparam logic [1:0] PHASE_GR = 2'b01;
  localparam logic [1:0] PHASE_GB = 2'b10;
  localparam logic [1:0] PHASE_B  = 2'b11;

  // Video timing counter geometry
  localparam int         CNT_W   = 11;
  localparam logic [10:0] CNT_MAX = 11'd2047;

  // Phase of a pixel: pattern bits flip the row/column parity so that every
  // layout reduces to the RGGB phase map.
  function automatic logic [1:0] cfa_phase(input logic       line_lsb,
                                           input logic       point_lsb,
                                           input logic [1:0] pattern);
    cfa_phase = {line_lsb ^ pattern[1], point_lsb ^ pattern[0]};
  endfunction

  // Pick the colour channel that the CFA keeps at the given phase.
  function automatic logic [7:0] cfa_select(input logic [1:0] phase,
                                            input logic [7:0] red,
                                            input logic [7:0] green,
                                            input logic [7:0] blue);
    case (phase)
      PHASE_R:  cfa_select = red;
      PHASE_GR: cfa_select = green;
      PHASE_GB: cfa_select = green;
      PHASE_B:  cfa_select = blue;
      default:  cfa_select = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/video_timing_cnt.sv
// Sync edge detection plus pixel/line position counters for a vsync/href
// video stream. After reset the stream is treated as unsynchronised until a
// vsync rising edge preceded by vsync low has been seen, so a frame that was
// cut by reset produces no edges that downstream logic would count or flag.
module video_timing_cnt
  import bayer_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             vsync,
  input  logic             href,
  output logic             vs_rise,
  output logic             vs_fall,
  output logic             hs_fall,
  output logic             sync_ok,
  output logic [CNT_W-1:0] point_cnt,
  output logic [CNT_W-1:0] line_cnt
);

  logic             vs_d_r;
  logic             hs_d_r;
  logic             armed_r;
  logic             sync_ok_r;
  logic [CNT_W-1:0] point_cnt_r;
  logic [CNT_W-1:0] line_cnt_r;

  // Qualified edge pulses derived from the current input and its registered copy
  always_comb begin
    vs_rise = vsync & ~vs_d_r & armed_r;
    vs_fall = ~vsync & vs_d_r & sync_ok_r;
    hs_fall = ~href & hs_d_r & sync_ok_r;
    sync_ok = sync_ok_r | vs_rise;
  end

  // Registered sync copies and the post-reset synchronisation state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_d_r    <= 1'b0;
      hs_d_r    <= 1'b0;
      armed_r   <= 1'b0;
      sync_ok_r <= 1'b0;
    end else begin
      vs_d_r    <= vsync;
      hs_d_r    <= href;
      armed_r   <= armed_r | ~vsync;
      sync_ok_r <= sync_ok_r | vs_rise;
    end
  end

  // Pixel position within the line: counts href-high cycles, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      point_cnt_r <= 11'd0;
    end else if (!href) begin
      point_cnt_r <= 11'd0;
    end else if (point_cnt_r != CNT_MAX) begin
      point_cnt_r <= point_cnt_r + 11'd1;
    end
  end

  // Line position within the frame: counts line ends while vsync is high, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_cnt_r <= 11'd0;
    end else if (!vsync) begin
      line_cnt_r <= 11'd0;
    end else if (hs_fall && (line_cnt_r != CNT_MAX)) begin
      line_cnt_r <= line_cnt_r + 11'd1;
    end
  end

  assign point_cnt = point_cnt_r;
  assign line_cnt  = line_cnt_r;

endmodule

// File: rtl/rgb888_raw8_mosaic.sv
// RGB888 to 8-bit Bayer RAW re-mosaic with selectable 2x2 CFA layout,
// one-cycle aligned sync outputs, sticky geometry error flags and a frame counter.
module rgb888_raw8_mosaic
  import bayer_pkg::*;
#(
  parameter logic [10:0] IMG_HDISP = 11'd640,
  parameter logic [10:0] IMG_VDISP = 11'd480
)(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic [7:0]  per_img_red,
  input  logic [7:0]  per_img_green,
  input  logic [7:0]  per_img_blue,
  input  logic [1:0]  bayer_pattern,
  input  logic        err_clr,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic [7:0]  post_img_RAW,
  output logic        line_len_err,
  output logic        frame_len_err,
  output logic [15:0] frame_cnt
);

  logic             vs_rise_s;
  logic             vs_fall_s;
  logic             hs_fall_s;
  logic             sync_ok_s;
  logic [CNT_W-1:0] point_cnt_s;
  logic [CNT_W-1:0] line_cnt_s;
  logic [1:0]       pattern_r;
  logic [1:0]       pattern_s;
  logic [1:0]       phase_s;
  logic [7:0]       raw_s;
  logic [15:0]      frame_cnt_r;

  video_timing_cnt u_timing (
    .clk       (clk),
    .rst_n     (rst_n),
    .vsync     (per_frame_vsync),
    .href      (per_frame_href),
    .vs_rise   (vs_rise_s),
    .vs_fall   (vs_fall_s),
    .hs_fall   (hs_fall_s),
    .sync_ok   (sync_ok_s),
    .point_cnt (point_cnt_s),
    .line_cnt  (line_cnt_s)
  );

  // Phase mux: the frame-start cycle already uses the newly sampled pattern
  always_comb begin
    pattern_s = pattern_r;
    raw_s     = 8'h00;
    if (vs_rise_s) begin
      pattern_s = bayer_pattern;
    end else begin
      pattern_s = pattern_r;
    end
    phase_s = cfa_phase(line_cnt_s[0], point_cnt_s[0], pattern_s);
    if (per_frame_href && (point_cnt_s < IMG_HDISP)) begin
      raw_s = cfa_select(phase_s, per_img_red, per_img_green, per_img_blue);
    end else begin
      raw_s = 8'h00;
    end
  end

  // CFA layout is latched once per frame so mid-frame changes wait for the next one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pattern_r <= BAYER_RGGB;
    end else if (vs_rise_s) begin
      pattern_r <= bayer_pattern;
    end
  end

  // Single output stage keeps syncs and RAW sample aligned; idle until synchronised
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_RAW     <= 8'h00;
    end else if (sync_ok_s) begin
      post_frame_vsync <= per_frame_vsync;
      post_frame_href  <= per_frame_href;
      post_img_RAW     <= raw_s;
    end else begin
      post_frame_vsync <= 1'b0;
      post_frame_href  <= 1'b0;
      post_img_RAW     <= 8'h00;
    end
  end

  // Sticky line length error; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_len_err <= 1'b0;
    end else if (hs_fall_s && (point_cnt_s != IMG_HDISP)) begin
      line_len_err <= 1'b1;
    end else if (err_clr) begin
      line_len_err <= 1'b0;
    end
  end

  // Sticky frame line-count error; a new error outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_len_err <= 1'b0;
    end else if (vs_fall_s && (line_cnt_s != IMG_VDISP)) begin
      frame_len_err <= 1'b1;
    end else if (err_clr) begin
      frame_len_err <= 1'b0;
    end
  end

  // Completed-frame counter, counts every frame end and wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_r <= 16'd0;
    end else if (vs_fall_s) begin
      frame_cnt_r <= frame_cnt_r + 16'd1;
    end
  end

  assign frame_cnt = frame_cnt_r;

endmodule
